dmem_arb: RTL and testbench
===========================

# dmem_arb

Two-requester arbiter sharing the single data-memory port between the MEM stage (loads/stores) and the instruction-fetch stage on a unified memory. Grants at most one access per cycle with same-cycle grant, tags each granted read, and returns read data one cycle later to the owning requester. Data accesses win conflicts by default. A bounded-wait counter guarantees fetch forward progress.

## Interface
- MAX_WAIT, 3, consecutive lost conflicts after which fetch wins the next conflict (1..15)
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_d_req  in  1  data request
- i_d_wen  in  1  1 = store, 0 = load
- i_d_addr  in  32  data byte address, already aligned by MEM stage
- i_d_wdata  in  32  store data, lane-aligned
- i_d_mask  in  4  byte-lane mask
- o_d_gnt  out  1  data request accepted this cycle
- o_d_rvld  out  1  load data valid
- o_d_rdata  out  32  load data, raw word
- i_f_req  in  1  fetch request
- i_f_addr  in  32  fetch address
- o_f_gnt  out  1  fetch accepted this cycle
- o_f_rvld  out  1  fetch data valid
- o_f_rdata  out  32  fetched word
- o_mem_addr  out  32  memory address
- o_mem_ren  out  1  memory read enable
- o_mem_wen  out  1  memory write enable
- o_mem_wdata  out  32  memory write data
- o_mem_mask  out  4  memory byte mask
- i_mem_rdata  in  32  memory read data, valid the cycle after o_mem_ren

## Operation
- Grant is combinational from current requests and state; a requester holds req/addr/data stable until gnt.
- Only D requesting: grant D. Only F: grant F. Neither: no grant; o_mem_ren=o_mem_wen=0, o_mem_addr/wdata=0, o_mem_mask=0.
- Conflict (both requesting): grant F if wait_cnt == MAX_WAIT, else grant D.
- wait_cnt (4 bits): +1 on a conflict that D wins; clears to 0 when F is granted or i_f_req=0; never exceeds MAX_WAIT.
- Granted D: o_mem_addr=i_d_addr, o_mem_wen=i_d_wen, o_mem_ren=~i_d_wen, o_mem_wdata=i_d_wdata, o_mem_mask=i_d_mask.
- Granted F: o_mem_addr=i_f_addr, o_mem_ren=1, o_mem_wen=0, o_mem_mask=4'hF, o_mem_wdata=0.
- Response tracking: registers rsp_vld_ff <= (granted read), rsp_own_ff <= owner (0=D, 1=F). Stores produce no response.
- o_d_rvld = rsp_vld_ff & ~rsp_own_ff; o_f_rvld = rsp_vld_ff & rsp_own_ff.
- o_d_rdata = o_f_rdata = i_mem_rdata; consumers qualify with their rvld.
- o_mem_ren and o_mem_wen are never both 1; at most one gnt per cycle.

## Timing
- Grant latency 0 cycles; read response latency exactly 1 cycle after grant; back-to-back reads every cycle, interleaved owners allowed.
- Reset values: wait_cnt=0, rsp_vld_ff=0, rsp_own_ff=0; hence o_d_rvld=o_f_rvld=0 the cycle after reset asserts.
- Reset while i_rst=1: o_d_gnt=o_f_gnt=0, o_mem_ren=o_mem_wen=0 (combinational gating).
- Reset mid-operation: a read granted the cycle before reset asserts has its response dropped (rvld=0).
- Worst-case fetch wait under continuous D traffic: MAX_WAIT+1 cycles from req to gnt.

## Structure
- Shared package dmem_arb_pkg: owner constants OWN_D=0, OWN_F=1, MAX_WAIT default.
- One sub-module natural: dmem_arb_age (saturating wait counter with conflict/clear inputs and at_max output).
- Arbiter top holds grant mux and response tag registers.

## Test plan
- Reset: assert i_rst 2 cycles with both reqs high -> no gnt, o_mem_ren/wen=0, both rvld=0.
- Single load: D req addr 0x100, ren -> o_d_gnt same cycle, o_mem_addr=0x100, mask from port; next cycle o_d_rvld=1, rdata=model word; o_f_rvld=0.
- Store: D req wen, mask 4'b0011, wdata 0x0000BEEF -> o_mem_wen=1, ren=0, no rvld next cycle.
- Starvation bound, MAX_WAIT=3: D and F both request continuously -> grants D,D,D,F repeating; F rvld one cycle after each F grant with fetch addr data.
- Interleave: cycle n F read 0x0, cycle n+1 D load 0x40 -> o_f_rvld at n+1, o_d_rvld at n+2, correct data each.
- Reset mid-read: grant F read, assert i_rst next cycle -> o_f_rvld=0, wait_cnt=0 afterwards.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory port arbiter: response owner tags
// and the default fetch wait bound.
package dmem_arb_pkg;
  localparam logic OWN_D        = 1'b0;
  localparam logic OWN_F        = 1'b1;
  localparam int   MAX_WAIT_DEF = 3;
  localparam int   CNT_W        = 4;
endpackage

// File: rtl/dmem_arb_age.sv
// Saturating count of consecutive conflicts lost by fetch; at_max tells the
// arbiter that fetch must win the next conflict.
module dmem_arb_age
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_C)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_max = (r_cnt == MAX_C);
endmodule

// File: rtl/dmem_arb.sv
// Arbiter for the shared data-memory port between the MEM stage and fetch:
// same-cycle grant, one-cycle tagged read return, bounded fetch starvation.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_d_req,
  input  logic        i_d_wen,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_mask,
  output logic        o_d_gnt,
  output logic        o_d_rvld,
  output logic [31:0] o_d_rdata,
  input  logic        i_f_req,
  input  logic [31:0] i_f_addr,
  output logic        o_f_gnt,
  output logic        o_f_rvld,
  output logic [31:0] o_f_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic [31:0] i_mem_rdata
);
  logic w_at_max;
  logic w_d_gnt;
  logic w_f_gnt;
  logic w_conflict;
  logic w_rd_gnt;
  logic r_rsp_vld;
  logic r_rsp_own;

  assign w_conflict = i_d_req & i_f_req;
  // Fetch wins a conflict only once it has lost MAX_WAIT in a row.
  assign w_f_gnt    = ~i_rst & i_f_req & (~i_d_req | w_at_max);
  assign w_d_gnt    = ~i_rst & i_d_req & ~w_f_gnt;
  assign w_rd_gnt   = w_f_gnt | (w_d_gnt & ~i_d_wen);

  dmem_arb_age #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    (w_conflict & w_d_gnt),
    .i_clr    (w_f_gnt | ~i_f_req),
    .o_at_max (w_at_max)
  );

  always_comb begin
    o_mem_addr  = '0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    o_mem_mask  = '0;
    if (w_d_gnt) begin
      o_mem_addr  = i_d_addr;
      o_mem_wen   = i_d_wen;
      o_mem_ren   = ~i_d_wen;
      o_mem_wdata = i_d_wdata;
      o_mem_mask  = i_d_mask;
    end else if (w_f_gnt) begin
      o_mem_addr  = i_f_addr;
      o_mem_ren   = 1'b1;
      o_mem_mask  = 4'hF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_vld <= 1'b0;
      r_rsp_own <= OWN_D;
    end else begin
      r_rsp_vld <= w_rd_gnt;
      r_rsp_own <= w_f_gnt ? OWN_F : OWN_D;
    end
  end

  assign o_d_gnt = w_d_gnt;
  assign o_f_gnt = w_f_gnt;
  // A response in flight when reset arrives is dropped, not delivered.
  assign o_d_rvld  = r_rsp_vld & (r_rsp_own == OWN_D) & ~i_rst;
  assign o_f_rvld  = r_rsp_vld & (r_rsp_own == OWN_F) & ~i_rst;
  assign o_d_rdata = i_mem_rdata;
  assign o_f_rdata = i_mem_rdata;
endmodule

// File: tb/tb_dmem_arb.sv
// Directed and randomized bench for dmem_arb with a word-array memory and a
// grant/response reference model.
module tb_dmem_arb;
  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_wen, f_req;
  logic [31:0] d_addr, d_wdata, f_addr;
  logic [3:0]  d_mask;
  logic        o_d_gnt, o_d_rvld, o_f_gnt, o_f_rvld;
  logic [31:0] o_d_rdata, o_f_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen;
  logic [3:0]  mem_mask;

  logic [31:0] mem [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          losses   = 0;
  bit          exp_d_rvld = 0, exp_f_rvld = 0;
  logic [31:0] exp_rdata = '0;
  bit          last_dg = 0, last_fg = 0;

  always #5 clk = ~clk;

  dmem_arb #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_d_req(d_req), .i_d_wen(d_wen), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .i_d_mask(d_mask), .o_d_gnt(o_d_gnt), .o_d_rvld(o_d_rvld), .o_d_rdata(o_d_rdata),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(o_f_gnt), .o_f_rvld(o_f_rvld),
    .o_f_rdata(o_f_rdata), .o_mem_addr(mem_addr), .o_mem_ren(mem_ren),
    .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: called at the falling edge with inputs already set.
  task automatic cycle();
    bit          e_dg, e_fg, e_ren, e_wen;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_mask;
    bit          s_ren, s_wen;
    logic [31:0] s_addr, s_wd;
    logic [3:0]  s_mask;
    #1;
    e_fg   = !rst && f_req && (!d_req || losses == MAX_WAIT);
    e_dg   = !rst && d_req && !e_fg;
    e_addr = e_dg ? d_addr : (e_fg ? f_addr : 32'h0);
    e_ren  = e_fg || (e_dg && !d_wen);
    e_wen  = e_dg && d_wen;
    e_wd   = e_dg ? d_wdata : 32'h0;
    e_mask = e_dg ? d_mask : (e_fg ? 4'hF : 4'h0);
    chk("d_gnt", 32'(o_d_gnt), 32'(e_dg));
    chk("f_gnt", 32'(o_f_gnt), 32'(e_fg));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_ren", 32'(mem_ren), 32'(e_ren));
    chk("mem_wen", 32'(mem_wen), 32'(e_wen));
    chk("mem_wdata", mem_wdata, e_wd);
    chk("mem_mask", 32'(mem_mask), 32'(e_mask));
    chk("d_rvld", 32'(o_d_rvld), 32'(exp_d_rvld && !rst));
    chk("f_rvld", 32'(o_f_rvld), 32'(exp_f_rvld && !rst));
    if (exp_d_rvld && !rst) chk("d_rdata", o_d_rdata, exp_rdata);
    if (exp_f_rvld && !rst) chk("f_rdata", o_f_rdata, exp_rdata);
    $display("t=%0t rst=%0b dreq=%0b freq=%0b gnt_d=%0b gnt_f=%0b addr=%h ren=%0b wen=%0b rvld_d=%0b rvld_f=%0b",
             $time, rst, d_req, f_req, o_d_gnt, o_f_gnt, mem_addr, mem_ren, mem_wen, o_d_rvld, o_f_rvld);
    exp_d_rvld = e_dg && !d_wen;
    exp_f_rvld = e_fg;
    exp_rdata  = e_ren ? mem[e_addr[9:2]] : 32'h0;
    if (rst || e_fg || !f_req) losses = 0;
    else if (d_req && e_dg && losses < MAX_WAIT) losses++;
    last_dg = e_dg;
    last_fg = e_fg;
    s_ren = mem_ren; s_wen = mem_wen; s_addr = mem_addr; s_wd = mem_wdata; s_mask = mem_mask;
    @(posedge clk);
    mem_rdata = s_ren ? mem[s_addr[9:2]] : 32'hDEAD_DEAD;
    if (s_wen) begin
      for (int b = 0; b < 4; b++)
        if (s_mask[b]) mem[s_addr[9:2]][b*8 +: 8] = s_wd[b*8 +: 8];
    end
    @(negedge clk);
  endtask

  task automatic idle();
    d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0; d_mask = 0;
    f_req = 0; f_addr = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem_rdata = 32'h0;
    idle();
    @(negedge clk);

    // Reset with both requesters active
    rst = 1; d_req = 1; d_addr = 32'h10; d_mask = 4'hF; f_req = 1; f_addr = 32'h4;
    cycle();
    cycle();
    chk("rst_d_rvld", 32'(o_d_rvld), 32'h0);
    chk("rst_f_rvld", 32'(o_f_rvld), 32'h0);
    rst = 0; idle();
    cycle();

    // Single load then idle to observe the response
    d_req = 1; d_addr = 32'h100; d_mask = 4'hF;
    #1 chk("load_gnt", 32'(o_d_gnt), 32'h1);
    chk("load_addr", mem_addr, 32'h100);
    cycle();
    idle();
    #1 chk("load_rvld", 32'(o_d_rvld), 32'h1);
    chk("load_data", o_d_rdata, mem[64]);
    cycle();

    // Partial store, then read it back
    d_req = 1; d_wen = 1; d_addr = 32'h80; d_mask = 4'b0011; d_wdata = 32'h0000BEEF;
    #1 chk("store_wen", 32'(mem_wen), 32'h1);
    chk("store_ren", 32'(mem_ren), 32'h0);
    cycle();
    idle();
    #1 chk("store_norvld", 32'(o_d_rvld), 32'h0);
    cycle();
    chk("store_lo", {16'h0, mem[32][15:0]}, 32'h0000BEEF);
    d_req = 1; d_addr = 32'h80; d_mask = 4'hF;
    cycle();
    idle();
    cycle();

    // Continuous conflict: expect D,D,D,F repeating
    d_req = 1; d_addr = 32'h44; d_mask = 4'hF; f_req = 1; f_addr = 32'hC;
    for (int i = 0; i < 12; i++) begin
      #1 chk("starve_fgnt", 32'(o_f_gnt), 32'((i % 4) == 3));
      cycle();
    end
    idle();
    cycle();

    // Interleaved owners on back-to-back reads
    f_req = 1; f_addr = 32'h0;
    cycle();
    idle(); d_req = 1; d_addr = 32'h40; d_mask = 4'hF;
    #1 chk("ilv_frvld", 32'(o_f_rvld), 32'h1);
    chk("ilv_fdata", o_f_rdata, mem[0]);
    cycle();
    idle();
    #1 chk("ilv_drvld", 32'(o_d_rvld), 32'h1);
    chk("ilv_ddata", o_d_rdata, mem[16]);
    cycle();

    // Fetch read followed by reset: response dropped
    f_req = 1; f_addr = 32'h20;
    cycle();
    rst = 1; idle();
    #1 chk("rstmid_frvld", 32'(o_f_rvld), 32'h0);
    cycle();
    rst = 0;
    cycle();

    // Build up losses, reset, then confirm the count restarted from zero
    d_req = 1; d_addr = 32'h8; d_mask = 4'hF; f_req = 1; f_addr = 32'h30;
    cycle();
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rstcnt_fgnt", 32'(o_f_gnt), 32'(i == 3));
      cycle();
    end
    idle();
    cycle();

    // Randomized traffic under the hold-until-grant protocol
    for (int i = 0; i < 400; i++) begin
      if (!d_req || last_dg) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_wen   = ($urandom_range(0, 2) == 0);
        d_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        d_wdata = $urandom;
        d_mask  = 4'($urandom_range(1, 15));
      end
      if (!f_req || last_fg) begin
        f_req  = ($urandom_range(0, 3) != 0);
        f_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      end
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 0; idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
